operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Pipeline stage between decode and execute. Accepts decoded instructions over a valid/ready handshake and issues read requests to the register file, which has a synchronous 1-cycle read.
- Presents rs1/rs2 operand values to execute one cycle later.
- Corrects operands for same-cycle and held-cycle writeback collisions (read-first RAM returns stale data) and forces x0 to zero.
- Holds operands stable under downstream backpressure and supports pipeline flush.

Parameters:
- PAYLOAD_W, 64, width of opaque decoded-instruction sideband carried alongside operands
- XLEN, 32, operand/register data width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush (branch/exception redirect)
- in_valid  input  1  decode has an instruction
- in_ready  output  1  stage can accept
- in_rs1_addr  input  5  source register 1 index
- in_rs2_addr  input  5  source register 2 index
- in_uses_rs1  input  1  instruction reads rs1
- in_uses_rs2  input  1  instruction reads rs2
- in_payload  input  PAYLOAD_W  decoded sideband
- rf_rd_en1  output  1  register file read enable, port 1
- rf_rd_en2  output  1  register file read enable, port 2
- rf_rd_addr1  output  5  register file read address, port 1
- rf_rd_addr2  output  5  register file read address, port 2
- rf_rs1  input  XLEN  register file read data 1, valid the cycle after rf_rd_en1; held while enable low
- rf_rs2  input  XLEN  register file read data 2, same timing
- wb_en  input  1  writeback write enable (same signal driving register file write)
- wb_addr  input  5  writeback register index
- wb_data  input  XLEN  writeback data
- out_valid  output  1  operands valid to execute
- out_ready  input  1  execute accepts
- out_rs1_data  output  XLEN  resolved operand 1
- out_rs2_data  output  XLEN  resolved operand 2
- out_payload  output  PAYLOAD_W  registered sideband
- stall_count  output  32  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0; payload, latched addresses/uses, override flags and values all 0; stall_count=0.
  - rf_rd_en1/2 forced 0 while rst_n low.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - On accept in cycle T:
    - rf_rd_addrN = in_rsN_addr (combinational passthrough).
    - rf_rd_enN = accept && in_usesN.
    - Address, uses and payload are latched.
    - out_valid=1 in cycle T+1.
  - Latency: exactly 1 cycle, in_valid to out_valid.
  - Back-to-back accepts at full throughput when out_ready=1.
- State:
  - EMPTY (out_valid=0) -> FULL on accept.
  - FULL -> EMPTY on out_ready && !accept.
  - FULL -> FULL on out_ready && accept (new instruction), or on !out_ready (hold).
  - Any state -> EMPTY on flush.
- Operand resolution, per operand N, evaluated each cycle:
  - If !usesN or addrN==0: out_rsN_data=0.
  - Else if overrideN: out_rsN_data=override_valN.
  - Else: out_rsN_data=rf_rsN.
- Override update:
  - On accept: overrideN <= wb_en && wb_addr==in_rsN_addr && in_rsN_addr!=0. override_valN <= wb_data.
  - While FULL and not being replaced: any wb_en && wb_addr==addrN && addrN!=0 sets overrideN and loads override_valN <= wb_data. Later writes overwrite earlier ones.
  - Writes to x0 never create an override.
- During hold:
  - rf_rd_en1/2 stay 0, so register file outputs are held.
  - Operands and payload stay stable except through writeback overrides.
- Output data when out_valid=0: don't-care; drive 0.
- Flush:
  - Takes priority over everything else.
  - out_valid <= 0; no accept; overrides cleared; rf_rd_en1/2=0 that cycle.
- stall_count: increments when out_valid && !out_ready && !flush; saturates at 0xFFFFFFFF.

Test Plan:
- Basic read: RF x5=0x11111111, x6=0x22222222. Issue rs1=5, rs2=6 with out_ready=1 -> next cycle out_valid=1, rs1=0x11111111, rs2=0x22222222, payload matches.
- Same-cycle collision: accept rs1=7 while wb writes x7=0xDEADBEEF; RF returns old 0x0 -> out_rs1_data=0xDEADBEEF.
- Hold + write: out_ready=0 for 3 cycles, wb writes rs2 register x9=0xCAFE0001 then 0xCAFE0002 -> operand reads 0xCAFE0002; stall_count=3; accept on release.
- x0/unused: rs1=0 with wb writing x0=0xFFFFFFFF, and in_uses_rs2=0 -> both operands 0; rf_rd_en2 never asserted.
- Throughput: 8 back-to-back instructions with out_ready=1 -> 8 consecutive out_valid cycles, in order, 1-cycle latency.
- Flush and reset: flush while FULL and in_valid=1 -> out_valid=0 next cycle, in_ready=0 during flush, no accept. Async rst_n low mid-hold -> out_valid=0 and stall_count=0 immediately.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch: issues register file reads on accept and presents resolved operands one cycle later.
// Writeback collisions on the read cycle and during hold are patched with captured override values.
module operand_fetch_stage #(
  parameter int PAYLOAD_W = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1_addr,
  input  logic [4:0]           in_rs2_addr,
  input  logic                 in_uses_rs1,
  input  logic                 in_uses_rs2,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 rf_rd_en1,
  output logic                 rf_rd_en2,
  output logic [4:0]           rf_rd_addr1,
  output logic [4:0]           rf_rd_addr2,
  input  logic [XLEN-1:0]      rf_rs1,
  input  logic [XLEN-1:0]      rf_rs2,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          stall_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             addr1_q, addr1_d, addr2_q, addr2_d;
  logic                   uses1_q, uses1_d, uses2_q, uses2_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic                   ovr1_q, ovr1_d, ovr2_q, ovr2_d;
  logic [XLEN-1:0]        ovr_val1_q, ovr_val1_d, ovr_val2_q, ovr_val2_d;
  logic [31:0]            stall_q, stall_d;
  logic                   accept;

  assign out_valid   = (state_q == FULL);
  assign in_ready    = !flush && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign rf_rd_addr1 = in_rs1_addr;
  assign rf_rd_addr2 = in_rs2_addr;
  // Enables are gated by rst_n so the RAM is not read while the stage is held in reset.
  assign rf_rd_en1   = rst_n && accept && in_uses_rs1;
  assign rf_rd_en2   = rst_n && accept && in_uses_rs2;
  assign stall_count = stall_q;

  always_comb begin
    state_d    = state_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    uses1_d    = uses1_q;
    uses2_d    = uses2_q;
    payload_d  = payload_q;
    ovr1_d     = ovr1_q;
    ovr2_d     = ovr2_q;
    ovr_val1_d = ovr_val1_q;
    ovr_val2_d = ovr_val2_q;
    stall_d    = stall_q;

    if (flush) begin
      state_d = EMPTY;
      ovr1_d  = 1'b0;
      ovr2_d  = 1'b0;
    end else if (accept) begin
      state_d    = FULL;
      addr1_d    = in_rs1_addr;
      addr2_d    = in_rs2_addr;
      uses1_d    = in_uses_rs1;
      uses2_d    = in_uses_rs2;
      payload_d  = in_payload;
      // The read-first RAM returns pre-write data for a same-cycle writeback.
      ovr1_d     = wb_en && (wb_addr == in_rs1_addr) && (in_rs1_addr != 5'd0);
      ovr2_d     = wb_en && (wb_addr == in_rs2_addr) && (in_rs2_addr != 5'd0);
      ovr_val1_d = wb_data;
      ovr_val2_d = wb_data;
    end else if (out_valid) begin
      if (out_ready) begin
        state_d = EMPTY;
      end
      if (wb_en && (wb_addr == addr1_q) && (addr1_q != 5'd0)) begin
        ovr1_d     = 1'b1;
        ovr_val1_d = wb_data;
      end
      if (wb_en && (wb_addr == addr2_q) && (addr2_q != 5'd0)) begin
        ovr2_d     = 1'b1;
        ovr_val2_d = wb_data;
      end
    end

    if (out_valid && !out_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      addr1_q    <= '0;
      addr2_q    <= '0;
      uses1_q    <= 1'b0;
      uses2_q    <= 1'b0;
      payload_q  <= '0;
      ovr1_q     <= 1'b0;
      ovr2_q     <= 1'b0;
      ovr_val1_q <= '0;
      ovr_val2_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      uses1_q    <= uses1_d;
      uses2_q    <= uses2_d;
      payload_q  <= payload_d;
      ovr1_q     <= ovr1_d;
      ovr2_q     <= ovr2_d;
      ovr_val1_q <= ovr_val1_d;
      ovr_val2_q <= ovr_val2_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    out_rs1_data = '0;
    out_rs2_data = '0;
    out_payload  = '0;
    if (out_valid) begin
      out_payload = payload_q;
      if (uses1_q && (addr1_q != 5'd0)) begin
        out_rs1_data = ovr1_q ? ovr_val1_q : rf_rs1;
      end
      if (uses2_q && (addr2_q != 5'd0)) begin
        out_rs2_data = ovr2_q ? ovr_val2_q : rf_rs2;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a read-first, hold-when-idle register file model.
module tb_operand_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic        in_uses_rs1;
  logic        in_uses_rs2;
  logic [63:0] in_payload;
  logic        rf_rd_en1;
  logic        rf_rd_en2;
  logic [4:0]  rf_rd_addr1;
  logic [4:0]  rf_rd_addr2;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [63:0] out_payload;
  logic [31:0] stall_count;

  int passed = 0;
  int total  = 0;

  logic [31:0] rf_mem [0:31];

  operand_fetch_stage #(.PAYLOAD_W(64), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_payload(in_payload),
    .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_payload(out_payload), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read-first, outputs held while enable is low, x0 not writable.
  always @(posedge clk) begin
    if (rf_rd_en1) rf_rs1 <= rf_mem[rf_rd_addr1];
    if (rf_rd_en2) rf_rs2 <= rf_mem[rf_rd_addr2];
    if (wb_en && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
  end

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic rf_preload;
    rf_write(5'd5, 32'h1111_1111);
    rf_write(5'd6, 32'h2222_2222);
    rf_write(5'd7, 32'h0000_0000);
    rf_write(5'd9, 32'h0000_0009);
    for (int i = 0; i < 8; i++) rf_write(5'(10 + i), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b1;
    in_rs1_addr = 5'd5; in_rs2_addr = 5'd6; in_payload = 64'hFFFF;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0h exp 0", out_valid); else passed++;
    total++; if (stall_count !== 32'd0) $display("FAIL reset_stall got %0h exp 0", stall_count); else passed++;
    total++; if (rf_rd_en1 !== 1'b0) $display("FAIL reset_rd_en1 got %0h exp 0", rf_rd_en1); else passed++;
    total++; if (rf_rd_en2 !== 1'b0) $display("FAIL reset_rd_en2 got %0h exp 0", rf_rd_en2); else passed++;
    total++; if (out_payload !== 64'd0) $display("FAIL reset_payload got %0h exp 0", out_payload); else passed++;
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_release_valid got %0h exp 0", out_valid); else passed++;
  endtask

  task automatic test_basic_read;
    @(negedge clk);
    in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs2_addr = 5'd6;
    in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b1; in_payload = 64'h0123_4567_89AB_CDEF; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %0h exp 1", in_ready); else passed++;
    total++; if (rf_rd_en1 !== 1'b1) $display("FAIL basic_rd_en1 got %0h exp 1", rf_rd_en1); else passed++;
    total++; if (rf_rd_addr2 !== 5'd6) $display("FAIL basic_rd_addr2 got %0d exp 6", rf_rd_addr2); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %0h exp 1", out_valid); else passed++;
    total++; if (out_rs1_data !== 32'h1111_1111) $display("FAIL basic_rs1 got %0h exp 11111111", out_rs1_data); else passed++;
    total++; if (out_rs2_data !== 32'h2222_2222) $display("FAIL basic_rs2 got %0h exp 22222222", out_rs2_data); else passed++;
    total++; if (out_payload !== 64'h0123_4567_89AB_CDEF) $display("FAIL basic_payload got %0h exp 0123456789abcdef", out_payload); else passed++;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL basic_drain got %0h exp 0", out_valid); else passed++;
    total++; if (out_rs1_data !== 32'd0) $display("FAIL basic_idle_rs1 got %0h exp 0", out_rs1_data); else passed++;
  endtask

  task automatic test_collision;
    @(negedge clk);
    in_valid = 1'b1; in_rs1_addr = 5'd7; in_rs2_addr = 5'd0;
    in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b0; in_payload = 64'hAA;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    in_valid = 1'b0; wb_en = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL coll_valid got %0h exp 1", out_valid); else passed++;
    total++; if (out_rs1_data !== 32'hDEAD_BEEF) $display("FAIL coll_rs1 got %0h exp deadbeef", out_rs1_data); else passed++;
    total++; if (out_rs2_data !== 32'd0) $display("FAIL coll_rs2 got %0h exp 0", out_rs2_data); else passed++;
  endtask

  task automatic test_hold_write;
    @(negedge clk);
    in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs2_addr = 5'd9;
    in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b1; in_payload = 64'h55; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready got %0h exp 0", in_ready); else passed++;
    total++; if (out_rs2_data !== 32'h9) $display("FAIL hold_rs2_init got %0h exp 9", out_rs2_data); else passed++;
    total++; if (stall_count !== 32'd0) $display("FAIL hold_stall0 got %0d exp 0", stall_count); else passed++;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE_0001;
    @(negedge clk);
    total++; if (out_rs2_data !== 32'hCAFE_0001) $display("FAIL hold_rs2_w1 got %0h exp cafe0001", out_rs2_data); else passed++;
    total++; if (stall_count !== 32'd1) $display("FAIL hold_stall1 got %0d exp 1", stall_count); else passed++;
    wb_data = 32'hCAFE_0002;
    @(negedge clk);
    wb_en = 1'b0;
    total++; if (stall_count !== 32'd2) $display("FAIL hold_stall2 got %0d exp 2", stall_count); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL hold_valid got %0h exp 1", out_valid); else passed++;
    total++; if (out_rs2_data !== 32'hCAFE_0002) $display("FAIL hold_rs2_w2 got %0h exp cafe0002", out_rs2_data); else passed++;
    total++; if (out_rs1_data !== 32'h1111_1111) $display("FAIL hold_rs1 got %0h exp 11111111", out_rs1_data); else passed++;
    total++; if (out_payload !== 64'h55) $display("FAIL hold_payload got %0h exp 55", out_payload); else passed++;
    total++; if (stall_count !== 32'd3) $display("FAIL hold_stall3 got %0d exp 3", stall_count); else passed++;
    out_ready = 1'b1; in_valid = 1'b1; in_rs1_addr = 5'd6; in_rs2_addr = 5'd5; in_payload = 64'h66;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL hold_release_ready got %0h exp 1", in_ready); else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_rs1_data !== 32'h2222_2222) $display("FAIL hold_next_rs1 got %0h exp 22222222", out_rs1_data); else passed++;
    total++; if (out_rs2_data !== 32'h1111_1111) $display("FAIL hold_next_rs2 got %0h exp 11111111", out_rs2_data); else passed++;
    total++; if (out_payload !== 64'h66) $display("FAIL hold_next_payload got %0h exp 66", out_payload); else passed++;
    total++; if (stall_count !== 32'd3) $display("FAIL hold_stall_after got %0d exp 3", stall_count); else passed++;
  endtask

  task automatic test_x0_unused;
    @(negedge clk);
    in_valid = 1'b1; in_rs1_addr = 5'd0; in_rs2_addr = 5'd6;
    in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b0; in_payload = 64'h00;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; out_ready = 1'b1;
    #1;
    total++; if (rf_rd_en2 !== 1'b0) $display("FAIL x0_rd_en2 got %0h exp 0", rf_rd_en2); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL x0_in_ready got %0h exp 1", in_ready); else passed++;
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL x0_valid got %0h exp 1", out_valid); else passed++;
    total++; if (out_rs1_data !== 32'd0) $display("FAIL x0_rs1 got %0h exp 0", out_rs1_data); else passed++;
    total++; if (out_rs2_data !== 32'd0) $display("FAIL x0_rs2_unused got %0h exp 0", out_rs2_data); else passed++;
    total++; if (rf_rd_en2 !== 1'b0) $display("FAIL x0_rd_en2_after got %0h exp 0", rf_rd_en2); else passed++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %0h exp 1", i - 1, out_valid); else passed++;
        total++; if (out_rs1_data !== 32'hA000_0000 + 32'(i - 1)) $display("FAIL b2b_rs1[%0d] got %0h exp %0h", i - 1, out_rs1_data, 32'hA000_0000 + 32'(i - 1)); else passed++;
        total++; if (out_rs2_data !== 32'h1111_1111) $display("FAIL b2b_rs2[%0d] got %0h exp 11111111", i - 1, out_rs2_data); else passed++;
        total++; if (out_payload !== 64'(i - 1)) $display("FAIL b2b_payload[%0d] got %0h exp %0h", i - 1, out_payload, i - 1); else passed++;
      end
      if (i < 8) begin
        in_valid = 1'b1; in_rs1_addr = 5'(10 + i); in_rs2_addr = 5'd5;
        in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b1; in_payload = 64'(i);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %0h exp 0", out_valid); else passed++;
  endtask

  task automatic test_flush;
    @(negedge clk);
    in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs2_addr = 5'd6;
    in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b1; in_payload = 64'h77; out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL flush_pre_valid got %0h exp 1", out_valid); else passed++;
    flush = 1'b1; in_valid = 1'b1; in_rs1_addr = 5'd6;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0h exp 0", in_ready); else passed++;
    total++; if (rf_rd_en1 !== 1'b0) $display("FAIL flush_rd_en1 got %0h exp 0", rf_rd_en1); else passed++;
    total++; if (rf_rd_en2 !== 1'b0) $display("FAIL flush_rd_en2 got %0h exp 0", rf_rd_en2); else passed++;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0h exp 0", out_valid); else passed++;
    total++; if (stall_count !== 32'd3) $display("FAIL flush_stall got %0d exp 3", stall_count); else passed++;
    total++; if (out_payload !== 64'd0) $display("FAIL flush_payload got %0h exp 0", out_payload); else passed++;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs2_addr = 5'd6;
    in_uses_rs1 = 1'b1; in_uses_rs2 = 1'b1; in_payload = 64'h88; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (stall_count !== 32'd4) $display("FAIL arst_pre_stall got %0d exp 4", stall_count); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL arst_pre_valid got %0h exp 1", out_valid); else passed++;
    #2;
    rst_n = 1'b0; in_valid = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %0h exp 0", out_valid); else passed++;
    total++; if (stall_count !== 32'd0) $display("FAIL arst_stall got %0d exp 0", stall_count); else passed++;
    total++; if (out_rs1_data !== 32'd0) $display("FAIL arst_rs1 got %0h exp 0", out_rs1_data); else passed++;
    total++; if (rf_rd_en1 !== 1'b0) $display("FAIL arst_rd_en1 got %0h exp 0", rf_rd_en1); else passed++;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL arst_after_valid got %0h exp 0", out_valid); else passed++;
    total++; if (stall_count !== 32'd0) $display("FAIL arst_after_stall got %0d exp 0", stall_count); else passed++;
  endtask

  initial begin
    test_reset();
    rf_preload();
    test_basic_read();
    test_collision();
    test_hold_write();
    test_x0_unused();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
